// File: rtl/qedmma_rdout_pkg.sv
// -----------------------------------------------------------------------------
// qedmma_rdout_pkg
// Shared types and defaults for the correlator readout scheduler.
//   rdout_state_e    : scheduler FSM states
//   MaxBanks         : largest supported bank count
//   DefCntW          : default frame / overrun counter width
//   DefTimeoutCycles : default watchdog limit (only used with the watchdog built in)
// -----------------------------------------------------------------------------
package qedmma_rdout_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StArb,
        StFire,
        StWaitBusy,
        StWaitDone
    } rdout_state_e;

    localparam int unsigned MaxBanks         = 16;
    localparam int unsigned DefCntW          = 16;
    localparam int unsigned DefTimeoutCycles = 4096;

endpackage

// File: rtl/qedmma_rr_arbiter.sv
// -----------------------------------------------------------------------------
// qedmma_rr_arbiter
// Combinational round-robin pick: first set request bit searching upward from
// the pointer, wrapping at NumBanks.
// Ports:
//   req_i       : request vector, one bit per bank
//   ptr_i       : highest-priority bank index
//   gnt_idx_o   : index of the granted bank (0 when nothing is requested)
//   gnt_valid_o : high when any request is set
// -----------------------------------------------------------------------------
module qedmma_rr_arbiter #(
    parameter int unsigned NumBanks = 4,
    parameter int unsigned IdxW     = $clog2(NumBanks)
) (
    input  logic [NumBanks-1:0] req_i,
    input  logic [IdxW-1:0]     ptr_i,
    output logic [IdxW-1:0]     gnt_idx_o,
    output logic                gnt_valid_o
);

    int unsigned     idx;
    logic [IdxW-1:0] cand;

    always_comb begin
        gnt_idx_o   = '0;
        gnt_valid_o = 1'b0;
        idx         = 0;
        cand        = '0;
        for (int unsigned i = 0; i < NumBanks; i++) begin
            idx  = (32'(ptr_i) + i) % NumBanks;
            cand = IdxW'(idx);
            if (!gnt_valid_o && req_i[cand]) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/qedmma_corr_readout_sched.sv
// -----------------------------------------------------------------------------
// qedmma_corr_readout_sched
// Shares one correlator PISO serializer between NUM_BANKS correlator banks.
// Each bank holds at most one pending dump; banks are granted round-robin.
// A grant drives the result-mux select, pulses the serializer load, then
// follows the serializer busy flag until the frame is out.
//
// Optional feature (compile-time macro QEDMMA_RDOUT_WATCHDOG_EN):
//   watchdog on the busy handshake; after TIMEOUT_CYCLES in WAIT_BUSY or
//   WAIT_DONE the FSM returns to IDLE and sets the sticky o_timeout.
//   Without the macro the FSM waits forever and o_timeout is 0.
//
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   i_enable         : allows new grants (in-flight transfer always completes)
//   i_dump_req       : per-bank dump request pulses
//   o_dump_ack       : one-hot pulse in the load cycle of the granted bank
//   o_sel            : result-mux select, held from grant until back in IDLE
//   o_piso_valid     : one-cycle serializer load pulse
//   i_piso_busy      : serializer busy flag
//   o_active         : FSM not in IDLE
//   o_pending        : pending request flags
//   o_frame_cnt      : completed transfers (wraps)
//   o_overrun_cnt    : total overruns (saturates)
//   o_overrun_flag   : sticky per-bank overrun flags
//   i_clr_status     : clears overrun flags/count and timeout
//   o_timeout        : sticky watchdog flag
// All outputs are decoded from registers only.
// -----------------------------------------------------------------------------
module qedmma_corr_readout_sched
    import qedmma_rdout_pkg::*;
#(
    parameter int unsigned NUM_BANKS      = 4,
    parameter int unsigned CNT_W          = DefCntW,
    parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_enable,
    input  logic [NUM_BANKS-1:0]         i_dump_req,
    output logic [NUM_BANKS-1:0]         o_dump_ack,
    output logic [$clog2(NUM_BANKS)-1:0] o_sel,
    output logic                         o_piso_valid,
    input  logic                         i_piso_busy,
    output logic                         o_active,
    output logic [NUM_BANKS-1:0]         o_pending,
    output logic [CNT_W-1:0]             o_frame_cnt,
    output logic [CNT_W-1:0]             o_overrun_cnt,
    output logic [NUM_BANKS-1:0]         o_overrun_flag,
    input  logic                         i_clr_status,
    output logic                         o_timeout
);

    localparam int unsigned IdxW = $clog2(NUM_BANKS);
    localparam int unsigned PopW = $clog2(MaxBanks + 1);

    rdout_state_e         state_q, state_d;
    logic [IdxW-1:0]      sel_q, sel_d;
    logic [IdxW-1:0]      ptr_q, ptr_d;
    logic [NUM_BANKS-1:0] pend_q, pend_d;
    logic [NUM_BANKS-1:0] oflag_q, oflag_d;
    logic [CNT_W-1:0]     fcnt_q, fcnt_d;
    logic [CNT_W-1:0]     ocnt_q, ocnt_d;

    logic [IdxW-1:0]      gnt_idx;
    logic                 gnt_valid;
    logic [NUM_BANKS-1:0] fire_mask;
    logic [NUM_BANKS-1:0] ovr;
    logic [PopW-1:0]      ovr_n;
    logic [CNT_W-1:0]     ocnt_base;
    logic [CNT_W:0]       ocnt_sum;

    qedmma_rr_arbiter #(
        .NumBanks (NUM_BANKS),
        .IdxW     (IdxW)
    ) u_arb (
        .req_i       (pend_q),
        .ptr_i       (ptr_q),
        .gnt_idx_o   (gnt_idx),
        .gnt_valid_o (gnt_valid)
    );

    // Bank being loaded this cycle; its pending bit is consumed here.
    always_comb begin
        fire_mask = '0;
        if (state_q == StFire) begin
            fire_mask[sel_q] = 1'b1;
        end
    end

    // A request landing on the firing bank re-arms it without an overrun.
    assign ovr    = i_dump_req & pend_q & ~fire_mask;
    assign pend_d = (pend_q & ~fire_mask) | i_dump_req;

    always_comb begin
        ovr_n = '0;
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            ovr_n = ovr_n + PopW'(ovr[b]);
        end
    end

    // Clear first, then apply this cycle's overruns so they survive a clear.
    always_comb begin
        oflag_d   = (i_clr_status ? '0 : oflag_q) | ovr;
        ocnt_base = i_clr_status ? '0 : ocnt_q;
        ocnt_sum  = {1'b0, ocnt_base} + (CNT_W + 1)'(ovr_n);
        ocnt_d    = ocnt_sum[CNT_W] ? '1 : ocnt_sum[CNT_W-1:0];
    end

`ifdef QEDMMA_RDOUT_WATCHDOG_EN
    localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);

    logic [WdW-1:0] wd_q, wd_d;
    logic           timeout_q, timeout_d;
`endif

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        fcnt_d  = fcnt_q;
`ifdef QEDMMA_RDOUT_WATCHDOG_EN
        wd_d      = wd_q;
        timeout_d = i_clr_status ? 1'b0 : timeout_q;
`endif

        case (state_q)
            StIdle: begin
                if (i_enable && (|pend_q) && !i_piso_busy) begin
                    state_d = StArb;
                end
            end
            StArb: begin
                if (gnt_valid) begin
                    sel_d   = gnt_idx;
                    ptr_d   = (gnt_idx == IdxW'(NUM_BANKS - 1)) ? '0 : gnt_idx + IdxW'(1);
                    state_d = StFire;
                end else begin
                    state_d = StIdle;
                end
            end
            StFire: begin
                state_d = StWaitBusy;
            end
            StWaitBusy: begin
                if (i_piso_busy) begin
                    state_d = StWaitDone;
                end
            end
            StWaitDone: begin
                if (!i_piso_busy) begin
                    fcnt_d  = fcnt_q + CNT_W'(1);
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

`ifdef QEDMMA_RDOUT_WATCHDOG_EN
        // A normal exit in the same cycle takes precedence over the timeout.
        if (state_q == StWaitBusy || state_q == StWaitDone) begin
            wd_d = wd_q + WdW'(1);
            if (state_d == state_q && wd_q == WdW'(TIMEOUT_CYCLES - 1)) begin
                state_d   = StIdle;
                timeout_d = 1'b1;
            end
        end
        if (state_d != state_q && (state_d == StWaitBusy || state_d == StWaitDone)) begin
            wd_d = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sel_q   <= '0;
            ptr_q   <= '0;
            pend_q  <= '0;
            oflag_q <= '0;
            fcnt_q  <= '0;
            ocnt_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            pend_q  <= pend_d;
            oflag_q <= oflag_d;
            fcnt_q  <= fcnt_d;
            ocnt_q  <= ocnt_d;
        end
    end

`ifdef QEDMMA_RDOUT_WATCHDOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_timeout = timeout_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign o_timeout          = 1'b0;
`endif

    assign o_dump_ack     = fire_mask;
    assign o_sel          = sel_q;
    assign o_piso_valid   = (state_q == StFire);
    assign o_active       = (state_q != StIdle);
    assign o_pending      = pend_q;
    assign o_frame_cnt    = fcnt_q;
    assign o_overrun_cnt  = ocnt_q;
    assign o_overrun_flag = oflag_q;

endmodule

// File: tb/tb_qedmma_corr_readout_sched.sv
// -----------------------------------------------------------------------------
// tb_qedmma_corr_readout_sched
// Table of per-cycle {inputs, expected outputs} for a single transfer and an
// overrun scenario, followed by hand-written sequences for enable gating,
// overrun counting/clear, mid-transfer reset, round-robin order, request/clear
// collision and (when compiled in) the watchdog.
// -----------------------------------------------------------------------------
module tb_qedmma_corr_readout_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        clr = 1'b0;
    logic        busy = 1'b0;
    logic [3:0]  req = 4'b0;

    logic [3:0]  o_dump_ack;
    logic [1:0]  o_sel;
    logic        o_piso_valid;
    logic        o_active;
    logic [3:0]  o_pending;
    logic [15:0] o_frame_cnt;
    logic [15:0] o_overrun_cnt;
    logic [3:0]  o_overrun_flag;
    logic        o_timeout;

    qedmma_corr_readout_sched #(
        .NUM_BANKS      (4),
        .CNT_W          (16),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_enable       (en),
        .i_dump_req     (req),
        .o_dump_ack     (o_dump_ack),
        .o_sel          (o_sel),
        .o_piso_valid   (o_piso_valid),
        .i_piso_busy    (busy),
        .o_active       (o_active),
        .o_pending      (o_pending),
        .o_frame_cnt    (o_frame_cnt),
        .o_overrun_cnt  (o_overrun_cnt),
        .o_overrun_flag (o_overrun_flag),
        .i_clr_status   (clr),
        .o_timeout      (o_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [3:0]  req;
        logic        busy;
        logic        clr;
        logic        pv;
        logic [3:0]  ack;
        logic [1:0]  sel;
        logic        act;
        logic [3:0]  pend;
        logic [15:0] fcnt;
        logic [15:0] ocnt;
        logic [3:0]  oflag;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   exp_frame = 0;

    function automatic vec_t mk(input logic e, input logic [3:0] r, input logic b, input logic c,
                                input logic pv, input logic [3:0] ack, input logic [1:0] sel,
                                input logic act, input logic [3:0] pend, input logic [15:0] fcnt,
                                input logic [15:0] ocnt, input logic [3:0] oflag);
        vec_t v;
        v.en = e;  v.req = r;  v.busy = b;  v.clr = c;
        v.pv = pv; v.ack = ack; v.sel = sel; v.act = act; v.pend = pend;
        v.fcnt = fcnt; v.ocnt = ocnt; v.oflag = oflag;
        return v;
    endfunction

    function automatic logic [48:0] pack_out();
        return {o_piso_valid, o_dump_ack, o_sel, o_active, o_pending, o_frame_cnt,
                o_overrun_cnt, o_overrun_flag, o_timeout};
    endfunction

    // Inputs change 1 time unit after the rising edge; outputs are read there too.
    task automatic step(input logic e, input logic [3:0] r, input logic b, input logic c);
        en = e; req = r; busy = b; clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Step from IDLE until the load pulse appears, bounded.
    task automatic wait_fire(output logic [1:0] s, output logic ok);
        ok = 1'b0;
        s  = 2'd0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 4'b0, 1'b0, 1'b0);
            if (o_piso_valid) begin
                ok = 1'b1;
                s  = o_sel;
                break;
            end
        end
    endtask

    // From the FIRE cycle: serializer raises busy one cycle later, then drops it.
    task automatic finish(input logic e, input logic [3:0] r, input string tag);
        step(e, r, 1'b0, 1'b0);
        step(e, 4'b0, 1'b1, 1'b0);
        step(e, 4'b0, 1'b0, 1'b0);
        exp_frame++;
        chk({tag, " idle after done"}, 64'(o_active), 64'd0);
        chk({tag, " frame_cnt"}, 64'(o_frame_cnt), 64'(exp_frame));
    endtask

    task automatic serve(input logic [1:0] exp_sel, input string tag);
        logic [1:0] s;
        logic       ok;
        wait_fire(s, ok);
        chk({tag, " load seen"}, 64'(ok), 64'd1);
        chk({tag, " sel"}, 64'(s), 64'(exp_sel));
        chk({tag, " ack"}, 64'(o_dump_ack), 64'(4'b0001 << exp_sel));
        finish(1'b1, 4'b0, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL global time limit reached");
        $fatal(1);
    end

    initial begin
        logic [1:0] s;
        logic       ok;

        // en req busy clr | pv ack sel act pend fcnt ocnt oflag
        tbl.push_back(mk(1, 4'b0100, 0, 0, 0, 4'b0000, 0, 0, 4'b0100, 0, 0, 4'b0000));
        tbl.push_back(mk(1, 4'b0000, 0, 0, 0, 4'b0000, 0, 1, 4'b0100, 0, 0, 4'b0000));
        tbl.push_back(mk(1, 4'b0000, 0, 0, 1, 4'b0100, 2, 1, 4'b0100, 0, 0, 4'b0000));
        tbl.push_back(mk(1, 4'b0000, 0, 0, 0, 4'b0000, 2, 1, 4'b0000, 0, 0, 4'b0000));
        tbl.push_back(mk(1, 4'b0000, 1, 0, 0, 4'b0000, 2, 1, 4'b0000, 0, 0, 4'b0000));
        tbl.push_back(mk(1, 4'b0000, 1, 0, 0, 4'b0000, 2, 1, 4'b0000, 0, 0, 4'b0000));
        tbl.push_back(mk(1, 4'b0000, 0, 0, 0, 4'b0000, 2, 0, 4'b0000, 1, 0, 4'b0000));
        tbl.push_back(mk(1, 4'b0000, 0, 0, 0, 4'b0000, 2, 0, 4'b0000, 1, 0, 4'b0000));
        tbl.push_back(mk(1, 4'b0001, 0, 0, 0, 4'b0000, 2, 0, 4'b0001, 1, 0, 4'b0000));
        tbl.push_back(mk(1, 4'b0000, 0, 0, 0, 4'b0000, 2, 1, 4'b0001, 1, 0, 4'b0000));
        tbl.push_back(mk(1, 4'b0000, 0, 0, 1, 4'b0001, 0, 1, 4'b0001, 1, 0, 4'b0000));
        tbl.push_back(mk(1, 4'b0010, 0, 0, 0, 4'b0000, 0, 1, 4'b0010, 1, 0, 4'b0000));
        tbl.push_back(mk(1, 4'b0000, 1, 0, 0, 4'b0000, 0, 1, 4'b0010, 1, 0, 4'b0000));
        tbl.push_back(mk(1, 4'b0010, 1, 0, 0, 4'b0000, 0, 1, 4'b0010, 1, 1, 4'b0010));
        tbl.push_back(mk(1, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 4'b0010, 2, 1, 4'b0010));
        tbl.push_back(mk(1, 4'b0000, 0, 0, 0, 4'b0000, 0, 1, 4'b0010, 2, 1, 4'b0010));
        tbl.push_back(mk(1, 4'b0000, 0, 0, 1, 4'b0010, 1, 1, 4'b0010, 2, 1, 4'b0010));
        tbl.push_back(mk(1, 4'b0000, 0, 0, 0, 4'b0000, 1, 1, 4'b0000, 2, 1, 4'b0010));
        tbl.push_back(mk(1, 4'b0000, 1, 0, 0, 4'b0000, 1, 1, 4'b0000, 2, 1, 4'b0010));
        tbl.push_back(mk(1, 4'b0000, 0, 0, 0, 4'b0000, 1, 0, 4'b0000, 3, 1, 4'b0010));
        tbl.push_back(mk(1, 4'b0000, 0, 1, 0, 4'b0000, 1, 0, 4'b0000, 3, 0, 4'b0000));
        tbl.push_back(mk(1, 4'b0000, 0, 0, 0, 4'b0000, 1, 0, 4'b0000, 3, 0, 4'b0000));

        // Reset state
        #12;
        chk("reset outputs", 64'(pack_out()), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single request on bank 2, then bank 1 overrun while bank 0 is in flight
        foreach (tbl[i]) begin
            step(tbl[i].en, tbl[i].req, tbl[i].busy, tbl[i].clr);
            chk($sformatf("vec%0d", i), 64'(pack_out()),
                64'({tbl[i].pv, tbl[i].ack, tbl[i].sel, tbl[i].act, tbl[i].pend, tbl[i].fcnt,
                     tbl[i].ocnt, tbl[i].oflag, 1'b0}));
        end
        exp_frame = 3;

        // Enable low: requests queue up, multi-bank overrun, clear vs overrun
        step(1'b0, 4'b0011, 1'b0, 1'b0);
        chk("en_low pending", 64'({o_active, o_pending}), 64'({1'b0, 4'b0011}));
        step(1'b0, 4'b0011, 1'b0, 1'b0);
        chk("double overrun", 64'({o_overrun_cnt, o_overrun_flag}), 64'({16'd2, 4'b0011}));
        step(1'b0, 4'b0001, 1'b0, 1'b1);
        chk("clr vs overrun", 64'({o_overrun_cnt, o_overrun_flag}), 64'({16'd1, 4'b0001}));
        step(1'b0, 4'b0000, 1'b0, 1'b1);
        chk("clr status", 64'({o_overrun_cnt, o_overrun_flag}), 64'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'b0000, 1'b0, 1'b0);
            chk($sformatf("en_low hold %0d", i), 64'({o_piso_valid, o_active}), 64'd0);
        end
        step(1'b1, 4'b0000, 1'b0, 1'b0);
        chk("en_high arb", 64'({o_active, o_piso_valid}), 64'(2'b10));
        step(1'b1, 4'b0000, 1'b0, 1'b0);
        chk("en_high fire b0", 64'({o_piso_valid, o_sel, o_dump_ack}),
            64'({1'b1, 2'd0, 4'b0001}));
        // Enable dropped mid-transfer: the transfer still completes
        finish(1'b0, 4'b0000, "en_drop b0");
        step(1'b0, 4'b0000, 1'b0, 1'b0);
        chk("en_drop no grant", 64'({o_active, o_pending}), 64'({1'b0, 4'b0010}));
        serve(2'd1, "en_restore b1");

        // Reset in the middle of a transfer
        step(1'b1, 4'b0001, 1'b0, 1'b0);
        wait_fire(s, ok);
        chk("pre-reset load seen", 64'(ok), 64'd1);
        step(1'b1, 4'b0000, 1'b0, 1'b0);
        rst_n = 1'b0;
        #2;
        chk("reset mid-transfer", 64'(pack_out()), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_frame = 0;
        repeat (3) step(1'b1, 4'b0000, 1'b0, 1'b0);
        chk("grant dropped by reset", 64'({o_active, o_pending}), 64'd0);

        // Round-robin order from pointer 0
        step(1'b1, 4'b1111, 1'b0, 1'b0);
        chk("all pending", 64'(o_pending), 64'(4'b1111));
        serve(2'd0, "rr b0");
        serve(2'd1, "rr b1");
        serve(2'd2, "rr b2");
        serve(2'd3, "rr b3");
        step(1'b1, 4'b1001, 1'b0, 1'b0);
        serve(2'd0, "rr wrap b0");
        serve(2'd3, "rr wrap b3");

        // Request arriving in the bank's own FIRE cycle
        step(1'b1, 4'b0100, 1'b0, 1'b0);
        wait_fire(s, ok);
        chk("collide load seen", 64'(ok), 64'd1);
        chk("collide sel", 64'(s), 64'd2);
        step(1'b1, 4'b0100, 1'b0, 1'b0);
        chk("collide no overrun", 64'({o_pending, o_overrun_cnt, o_overrun_flag}),
            64'({4'b0100, 16'd0, 4'b0000}));
        step(1'b1, 4'b0000, 1'b1, 1'b0);
        step(1'b1, 4'b0000, 1'b0, 1'b0);
        exp_frame++;
        chk("collide frame", 64'(o_frame_cnt), 64'(exp_frame));
        serve(2'd2, "collide regrant b2");

`ifdef QEDMMA_RDOUT_WATCHDOG_EN
        // Busy stuck high: timeout after 16 cycles in WAIT_DONE
        step(1'b1, 4'b0001, 1'b0, 1'b0);
        wait_fire(s, ok);
        chk("wd load seen", 64'(ok), 64'd1);
        step(1'b1, 4'b0000, 1'b0, 1'b0);
        step(1'b1, 4'b0000, 1'b1, 1'b0);
        repeat (15) step(1'b1, 4'b0000, 1'b1, 1'b0);
        chk("wd still waiting", 64'({o_active, o_timeout}), 64'(2'b10));
        step(1'b1, 4'b0000, 1'b1, 1'b0);
        chk("wd fired", 64'({o_active, o_timeout, o_frame_cnt}),
            64'({1'b0, 1'b1, 16'(exp_frame)}));
        step(1'b1, 4'b0000, 1'b0, 1'b1);
        chk("wd cleared", 64'(o_timeout), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
